// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [WORD_W-1:0] pc_align(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_fifo.sv
// fetch_fifo: small synchronous prefetch FIFO holding {pc, instruction}.
// The head entry is readable combinationally so the core sees it with no
// extra cycle; flush empties the queue in one cycle and beats push/pop.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: owns the PC, issues in-order word fetches, buffers the
// returned words and hands {instruction, pc, pc+4} to the core.
// Build option: define FETCH_BYPASS_EN to present a response directly on
// inst_* in its arrival cycle when nothing is buffered ahead of it.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  fetch_state_t     state_reg;
  logic [31:0]      fetch_pc_reg;
  logic [31:0]      resp_pc_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   credit_sum;
  logic [CNT_W-1:0] redirect_drop;
  logic             req_fire;
  logic             resp_keep;
  logic             bypass;
  logic [63:0]      head;
  logic [63:0]      fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata ({resp_pc_reg, imem_resp_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // Request credits, response routing and the core-facing view of the head.
  always_comb begin
    credit_sum     = {1'b0, outstanding_reg} + {1'b0, occupancy};
    // A slot is reserved for every in-flight fetch, so a response can never
    // find the FIFO full; the request address only moves on accept/redirect.
    imem_req_valid = (state_reg != BOOT) && (credit_sum < (CNT_W+1)'(FIFO_DEPTH))
                     && !redirect_valid;
    imem_req_addr  = fetch_pc_reg;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_keep      = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    // A response landing in the redirect cycle is stale and already discarded.
    redirect_drop  = outstanding_reg - CNT_W'(imem_resp_valid);
`ifdef FETCH_BYPASS_EN
    bypass         = resp_keep && fifo_empty;
`else
    bypass         = 1'b0;
`endif
    head           = bypass ? {resp_pc_reg, imem_resp_data} : fifo_rdata;
    inst_valid     = !fifo_empty || bypass;
    inst_data      = inst_valid ? head[31:0]  : '0;
    inst_pc        = inst_valid ? head[63:32] : '0;
    inst_pc_plus4  = inst_valid ? head[63:32] + PC_INC : '0;
    // A bypassed word consumed in its arrival cycle never enters the FIFO.
    fifo_push      = resp_keep && !(bypass && inst_ready);
    fifo_pop       = !fifo_empty && inst_ready && !redirect_valid;
  end

  // Fetch state machine with PC, credit and stale-response bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
      assert (!(imem_resp_valid && (outstanding_reg == '0)));

      outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

      if (redirect_valid) begin
        fetch_pc_reg <= pc_align(redirect_pc);
        resp_pc_reg  <= pc_align(redirect_pc);
        drop_cnt_reg <= redirect_drop;
      end else begin
        if (req_fire) begin
          fetch_pc_reg <= fetch_pc_reg + PC_INC;
        end
        if (imem_resp_valid) begin
          if (drop_cnt_reg != '0) begin
            drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
          end else begin
            resp_pc_reg <= resp_pc_reg + PC_INC;
          end
        end
      end

      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (redirect_valid && (redirect_drop != '0)) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (redirect_valid) begin
            state_reg <= (redirect_drop != '0) ? FLUSH : RUN;
          end else if (imem_resp_valid && (drop_cnt_reg == CNT_W'(1))) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a fixed-latency in-order memory.
// Honors FETCH_BYPASS_EN for the one latency-dependent expectation.
module tb_mips_fetch_unit;

  localparam logic [31:0] K = 32'h5A5A_A5A5;  // memory returns addr ^ K
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        mem_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int compared   = 0;
  int mismatched = 0;
  int lat        = 1;

  logic [3:0]  pv;
  logic [31:0] pa [4];

  logic [31:0] req_log [$];
  logic [31:0] cons_pc [$];
  logic [31:0] cons_data [$];
  logic [31:0] cons_p4 [$];

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (mem_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  // Fixed-latency memory pipeline, reset by the same signal as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
    end else begin
      pv <= {1'b0, pv[3:1]};
      for (int i = 0; i < 3; i++) pa[i] <= pa[i+1];
      if (imem_req_valid && mem_ready) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_req_addr;
      end
    end
  end
  assign imem_resp_valid = pv[0];
  assign imem_resp_data  = pa[0] ^ K;

  // Transaction logs: accepted requests and instructions taken by the core.
  always @(posedge clk) begin
    if (reset && imem_req_valid && mem_ready) req_log.push_back(imem_req_addr);
    if (reset && inst_valid && inst_ready && !redirect_valid) begin
      cons_pc.push_back(inst_pc);
      cons_data.push_back(inst_data);
      cons_p4.push_back(inst_pc_plus4);
      $display("inst pc=%h data=%h pc4=%h", inst_pc, inst_data, inst_pc_plus4);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    req_log.delete();
    cons_pc.delete();
    cons_data.delete();
    cons_p4.delete();
  endtask

  // Assert reset across a negedge, optionally change latency, then release.
  task automatic do_reset(input int new_lat);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lat = new_lat;
    clear_logs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int          found;

    reset          = 1'b0;
    mem_ready      = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 1;

    // Reset state
    tick(2);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_pc4", inst_pc_plus4, 0);

    // Latency 1 streaming from RESET_PC
    reset = 1'b1;
    tick(1);
    chk("boot_req_valid", imem_req_valid, 1);
    chk("boot_req_addr", imem_req_addr, 32'h0);
    tick(1);
    chk("l1_resp_valid", imem_resp_valid, 1);
    chk("l1_inst_valid_resp_cycle", inst_valid, BYP);
    tick(1);
    chk("l1_inst_valid_next", inst_valid, 1);
    tick(6);
    chk("l1_req0", req_log[0], 32'h0);
    chk("l1_req1", req_log[1], 32'h4);
    chk("l1_req2", req_log[2], 32'h8);
    chk("l1_pc0", cons_pc[0], 32'h0);
    chk("l1_pc1", cons_pc[1], 32'h4);
    chk("l1_pc2", cons_pc[2], 32'h8);
    chk("l1_data1", cons_data[1], 32'h5A5A_A5A1);
    chk("l1_pc4_2", cons_p4[2], 32'hC);

    // Address held stable while memory stalls
    mem_ready = 1'b0;
    exp_addr  = req_log[req_log.size()-1] + 32'd4;
    tick(3);
    chk("stall_req_valid", imem_req_valid, 1);
    chk("stall_req_addr", imem_req_addr, exp_addr);
    mem_ready = 1'b1;
    tick(2);
    chk("stall_accept", req_log[req_log.size()-1], exp_addr + 32'd4);

    // Core back-pressure: FIFO fills to exactly four, then drains in order
    inst_ready = 1'b0;
    do_reset(1);
    tick(20);
    chk("bp_req_count", req_log.size(), 4);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_inst_valid", inst_valid, 1);
    chk("bp_head_pc", inst_pc, 32'h0);
    chk("bp_head_data", inst_data, K);
    inst_ready = 1'b1;
    tick(8);
    chk("bp_pc0", cons_pc[0], 32'h0);
    chk("bp_pc1", cons_pc[1], 32'h4);
    chk("bp_pc2", cons_pc[2], 32'h8);
    chk("bp_pc3", cons_pc[3], 32'hC);
    chk("bp_resume_req", req_log[4], 32'h10);
    chk("bp_resume_pc", cons_pc[4], 32'h10);

    // Latency 3, redirect with two fetches in flight
    do_reset(3);
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("rd1_req_valid_suppressed", imem_req_valid, 0);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("rd1_req_valid", imem_req_valid, 1);
    chk("rd1_req_addr", imem_req_addr, 32'h100);
    chk("rd1_stale0_hidden", inst_valid, 0);
    tick(1);
    chk("rd1_stale1_hidden", inst_valid, 0);
    tick(10);
    chk("rd1_pc0", cons_pc[0], 32'h100);
    chk("rd1_data0", cons_data[0], 32'h100 ^ K);
    chk("rd1_pc1", cons_pc[1], 32'h104);

    // Misaligned redirect target is forced to a word boundary
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("rd2_req_addr", imem_req_addr, 32'h200);
    tick(12);
    chk("rd2_req0", req_log[0], 32'h200);
    chk("rd2_pc0", cons_pc[0], 32'h200);

    // Redirect coinciding with a response and a pop
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick(1);
      if (imem_resp_valid && inst_valid) found = 1;
    end
    chk("rd3_found_collision", found, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    tick(15);
    chk("rd3_pc0", cons_pc[0], 32'h300);
    chk("rd3_pc1", cons_pc[1], 32'h304);
    chk("rd3_pc2", cons_pc[2], 32'h308);
    chk("rd3_data2", cons_data[2], 32'h308 ^ K);

    // PC wrap at the top of the address space
    do_reset(1);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(6);
    chk("wrap_req_count_ok", req_log.size() >= 2, 1);
    chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
    chk("wrap_req1", req_log[1], 32'h0);
    chk("wrap_cons_count_ok", cons_pc.size() >= 2, 1);
    chk("wrap_pc0", cons_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc4_0", cons_p4[0], 32'h0);
    chk("wrap_pc1", cons_pc[1], 32'h0);

    // Asynchronous reset mid-burst
    chk("arst_pre_req_valid", imem_req_valid, 1);
    chk("arst_pre_inst_valid", inst_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    clear_logs();
    reset = 1'b1;
    tick(6);
    chk("arst_req_count_ok", req_log.size() >= 1, 1);
    chk("arst_req0", req_log[0], 32'h0);
    chk("arst_cons_count_ok", cons_pc.size() >= 1, 1);
    chk("arst_pc0", cons_pc[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
